delay_line: RTL and testbench

DELAY_LINE -- requirements
Module: delay_line

---
 rtl/delay_line.sv | 89 ++++++++
 tb/tb_delay_line.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/delay_line.sv
// Programmable-delay circular buffer with a registered, strobe-qualified output.
// Optional DELAY_LINE_FILL_EN zeroes output samples taken before the line is primed.
module delay_line #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [ADDR-1:0]  delay,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             primed
);

  localparam int DEPTH = 1 << ADDR;
  localparam logic [ADDR:0] FULL = {1'b1, {ADDR{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR:0]    fill_q, fill_d;
  logic [ADDR-1:0]  d_q, d_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             primed_q, primed_d;

  logic [ADDR-1:0]  rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             chg;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    d_d         = d_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    primed_d    = primed_q;
    rd_addr     = wr_ptr_q - delay;
    rd_data     = mem[rd_addr];
    chg         = (delay != d_q);
    if (in_valid) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      d_d         = delay;
      // A new delay restarts the fill count; this strobe counts as one.
      if (chg)
        fill_d = {{ADDR{1'b0}}, 1'b1};
      else if (fill_q != FULL)
        fill_d = fill_q + 1'b1;
      primed_d    = (fill_d >= {1'b0, delay});
      out_valid_d = 1'b1;
      out_data_d  = (delay == '0) ? in_data : rd_data;
`ifdef DELAY_LINE_FILL_EN
      if (!primed_d)
        out_data_d = '0;
`endif
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      primed_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      primed_q    <= primed_d;
    end
  end

  // Storage is never cleared; writes are simply blocked during reset.
  always_ff @(posedge ck) begin
    if (in_valid && !rst)
      mem[wr_ptr_q] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_delay_line.sv
// Randomized bench for delay_line against a strobe-history reference model.
// Build with DELAY_LINE_FILL_EN to exercise output masking.
module tb_delay_line;

  localparam int W = 16;
  localparam int A = 8;
  localparam int N = 1 << A;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic [A-1:0] delay = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         primed;

  delay_line #(.WIDTH(W), .ADDR(A)) dut (
    .ck(ck), .rst(rst), .delay(delay),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .primed(primed)
  );

  always #5 ck = ~ck;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every location remembers the last sample written there.
  int m_val [N];
  bit m_known [N];
  int m_cnt;
  int m_d;
  int m_fill;
  bit m_primed;
  int m_out;
  bit m_out_known;

  task automatic model_reset();
    m_cnt = 0; m_d = 0; m_fill = 0;
    m_primed = 0; m_out = 0; m_out_known = 1;
  endtask

  task automatic model_strobe(input int d, input int x);
    int src;
    if (d != m_d) m_fill = 1;
    else if (m_fill < N) m_fill = m_fill + 1;
    m_d = d;
    m_primed = (m_fill >= d);
    if (d == 0) begin
      m_out = x; m_out_known = 1;
    end else begin
      src = (m_cnt - d) % N;
      if (src < 0) src += N;
      m_out = m_val[src]; m_out_known = m_known[src];
    end
`ifdef DELAY_LINE_FILL_EN
    if (!m_primed) begin
      m_out = 0; m_out_known = 1;
    end
`endif
    m_val[m_cnt % N] = x;
    m_known[m_cnt % N] = 1;
    m_cnt++;
  endtask

  task automatic cyc(input bit v, input int d, input int x, input string tag);
    in_valid = v;
    delay = A'(d);
    in_data = W'(x);
    @(posedge ck);
    #1;
    if (v) model_strobe(d, x);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".primed"}, 32'(primed), 32'(m_primed));
    if (m_out_known)
      chk({tag, ".data"}, 32'(out_data), 32'(m_out));
    in_valid = 1'b0;
  endtask

  initial begin
    int d;
    for (int i = 0; i < N; i++) m_known[i] = 0;
    model_reset();
    #12;
    chk("rst.valid", 32'(out_valid), 32'(0));
    chk("rst.data", 32'(out_data), 32'(0));
    chk("rst.primed", 32'(primed), 32'(0));
    @(negedge ck);
    rst = 1'b0;
    @(posedge ck);
    #1;

    cyc(1, 0, 16'hA5A5, "bypass");
    chk("bypass.abs", 32'(out_data), 32'h0000A5A5);
    chk("bypass.pr", 32'(primed), 32'(1));
    cyc(0, 0, 0, "bypass_idle");

    for (int k = 1; k <= 20; k++) begin
      cyc(1, 3, k, "d3");
      if (k >= 4) chk("d3.abs", 32'(out_data), 32'(k - 3));
    end

    for (int k = 0; k < 12; k++) begin
      cyc(1, 4, int'($urandom_range(0, 16'hFFFF)), "d4s");
      cyc(0, 4, 0, "d4s_idle1");
      cyc(0, 4, 0, "d4s_idle2");
    end

    for (int k = 0; k < 10; k++)
      cyc(1, 4, int'($urandom_range(0, 16'hFFFF)), "chg4");
    for (int k = 0; k < 6; k++) begin
      cyc(1, 2, int'($urandom_range(0, 16'hFFFF)), "chg2");
      chk("chg2.pr", 32'(primed), 32'(k >= 1));
    end

    for (int k = 0; k < 600; k++) begin
      cyc(1, 255, k, "d255");
      if (k >= 255) chk("d255.abs", 32'(out_data), 32'(k - 255));
    end

    // Asynchronous reset between clock edges while streaming.
    for (int k = 0; k < 5; k++)
      cyc(1, 2, int'($urandom_range(0, 16'hFFFF)), "pre_rst");
    in_valid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst.valid", 32'(out_valid), 32'(0));
    chk("arst.data", 32'(out_data), 32'(0));
    chk("arst.primed", 32'(primed), 32'(0));
    model_reset();
    @(posedge ck);
    #1;
    chk("arst.hold", 32'(out_valid), 32'(0));
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge ck);
    #1;
    cyc(0, 2, 0, "post_idle");
    for (int k = 0; k < 8; k++)
      cyc(1, 2, int'($urandom_range(0, 16'hFFFF)), "post_rst");

    d = 5;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0) d = int'($urandom_range(0, 12));
      cyc(bit'($urandom_range(0, 2) != 0), d,
          int'($urandom_range(0, 16'hFFFF)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
